// File: rtl/display_restador_if.sv
// Capture/handshake bundle between the adder/subtractor side and the display stage.
interface display_restador_if;
  logic       load;
  logic [3:0] S;
  logic       Cout;
  logic       select;
  logic       busy;
  logic       done;

  modport master (output load, S, Cout, select, input busy, done);
  modport slave  (input load, S, Cout, select, output busy, done);
endinterface

// File: rtl/display_restador.sv
// Captures a signed adder/subtractor result, converts it to BCD by double-dabble
// and drives a three-digit multiplexed seven-segment display (sign, tens, units).
module display_restador #(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter bit          COMMON_ANODE = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  display_restador_if.slave  bus,
  output logic [6:0]         seg,
  output logic [2:0]         an
);

  localparam int unsigned     CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_POL = COMMON_ANODE ? 7'h7F : 7'h00;
  localparam logic [2:0]      AN_POL  = COMMON_ANODE ? 3'b111 : 3'b000;
  localparam logic [2:0]      LAST_BIT = 3'd4;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q;
  logic [4:0] val_q;
  logic [3:0] tens_q, units_q;
  logic       neg_q;
  logic [3:0] disp_tens_q, disp_units_q;
  logic       disp_neg_q;
  logic       busy_q, done_q;
  logic       capture_c, shift_c, commit_c, busy_d, done_d;
  logic [3:0] units_adj_c;

  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       idx_q;
  logic [6:0]       seg_c;
  logic [2:0]       an_c;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h3F;
      4'd1:    seg_code = 7'h06;
      4'd2:    seg_code = 7'h5B;
      4'd3:    seg_code = 7'h4F;
      4'd4:    seg_code = 7'h66;
      4'd5:    seg_code = 7'h6D;
      4'd6:    seg_code = 7'h7D;
      4'd7:    seg_code = 7'h07;
      4'd8:    seg_code = 7'h7F;
      4'd9:    seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; a load during the done cycle is dropped, not queued
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.load && !busy_q && !done_q) state_d = SHIFT;
      SHIFT:   if (bit_cnt_q == LAST_BIT) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs (busy/done are registered below)
  always_comb begin
    capture_c = 1'b0;
    shift_c   = 1'b0;
    commit_c  = 1'b0;
    capture_c = (state_q == IDLE) && (state_d == SHIFT);
    shift_c   = (state_q == SHIFT);
    commit_c  = (state_q == COMMIT);
    busy_d    = (state_d != IDLE);
    done_d    = commit_c;
  end

  // Units correction only; the value never exceeds 30 so tens stays below 5
  assign units_adj_c = (units_q >= 4'd5) ? units_q + 4'd3 : units_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      bit_cnt_q    <= 3'd0;
      val_q        <= 5'd0;
      tens_q       <= 4'd0;
      units_q      <= 4'd0;
      neg_q        <= 1'b0;
      disp_tens_q  <= 4'd0;
      disp_units_q <= 4'd0;
      disp_neg_q   <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      if (capture_c) begin
        val_q     <= bus.select ? {1'b0, bus.S} : {bus.Cout, bus.S};
        // A negative zero is shown as plain 0
        neg_q     <= bus.select && !bus.Cout && (bus.S != 4'd0);
        tens_q    <= 4'd0;
        units_q   <= 4'd0;
        bit_cnt_q <= 3'd0;
      end
      if (shift_c) begin
        tens_q    <= {tens_q[2:0], units_adj_c[3]};
        units_q   <= {units_adj_c[2:0], val_q[4]};
        val_q     <= {val_q[3:0], 1'b0};
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (commit_c) begin
        disp_tens_q  <= tens_q;
        disp_units_q <= units_q;
        disp_neg_q   <= neg_q;
      end
    end
  end

  // Digit content for the currently scanned position, active-high
  always_comb begin
    seg_c = 7'h00;
    an_c  = 3'b000;
    case (idx_q)
      2'd0: begin
        seg_c = seg_code(disp_units_q);
        an_c  = 3'b001;
      end
      2'd1: begin
        seg_c = (disp_tens_q != 4'd0) ? seg_code(disp_tens_q) : 7'h00;
        an_c  = 3'b010;
      end
      default: begin
        seg_c = disp_neg_q ? 7'h40 : 7'h00;
        an_c  = 3'b100;
      end
    endcase
  end

  // Refresh scan runs free, independent of conversions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= 2'd0;
      seg   <= SEG_POL;
      an    <= AN_POL;
    end else begin
      if (cnt_q == CNT_MAX) begin
        cnt_q <= '0;
        idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      seg <= seg_c ^ SEG_POL;
      an  <= an_c ^ AN_POL;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule
